// File: rtl/seq_step_controller_if.sv
// Button inputs and step/mode outputs between the push-button front end
// and the up/down sequence state machine.
interface seq_step_controller_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_auto;
    logic       btn_blank;
    logic       step_up;
    logic       step_down;
    logic [1:0] mode;

    modport master (
        output btn_up, btn_down, btn_auto, btn_blank,
        input  step_up, step_down, mode
    );

    modport slave (
        input  btn_up, btn_down, btn_auto, btn_blank,
        output step_up, step_down, mode
    );
endinterface

// File: rtl/seq_step_controller.sv
// Debounced push-button front end producing single-cycle UP/DOWN pulses for the
// 9-digit sequence machine. Define AUTOREPEAT_EN for hold-to-repeat in MANUAL.
module seq_step_controller #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter logic [31:0] TICK_DIV   = 32'd25000000,
    parameter int          CNT_W      = 32
) (
    input logic                  clock,
    input logic                  reset,
    seq_step_controller_if.slave bus
);

    typedef enum logic [1:0] {
        MANUAL    = 2'b00,
        AUTO_UP   = 2'b01,
        AUTO_DOWN = 2'b10
    } mode_t;

    localparam logic [15:0]      DEB_LAST  = DEB_CYCLES - 16'd1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Bit order for all per-button vectors: 0 up, 1 down, 2 auto, 3 blank.
    logic [3:0]  btn_raw;
    logic [3:0]  sync_p0;
    logic [3:0]  sync_p1;
    logic [3:0]  deb_p2;
    logic [3:0]  deb_p3;
    logic [15:0] deb_cnt [4];

    logic [3:0]       ev;
    logic             ev_up, ev_down, ev_auto, ev_blank;
    logic             rep_hold;
    logic             count_en;
    logic             tick;
    logic [CNT_W-1:0] presc;
    mode_t            mode;
    mode_t            dir_nxt;
    logic             step_up_q;
    logic             step_down_q;

    assign btn_raw = {bus.btn_blank, bus.btn_auto, bus.btn_down, bus.btn_up};

    // Stages p0/p1: two-flop synchroniser; p2: debounced level; p3: delayed level for edge detect
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb_p2  <= '0;
            deb_p3  <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            deb_p3  <= deb_p2;
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == deb_p2[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_p2[i]  <= sync_p1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign ev       = deb_p2 & ~deb_p3;
    assign ev_up    = ev[0];
    assign ev_down  = ev[1];
    assign ev_auto  = ev[2];
    assign ev_blank = ev[3];

`ifdef AUTOREPEAT_EN
    // Exactly one of up/down held in MANUAL keeps the prescaler running.
    assign rep_hold = (mode == MANUAL) && (deb_p2[0] ^ deb_p2[1]);
`else
    assign rep_hold = 1'b0;
`endif

    assign count_en = (mode != MANUAL) || rep_hold;
    assign tick     = count_en && (presc == TICK_LAST);

    // A button press in auto mode retargets the direction before any same-cycle tick.
    always_comb begin
        dir_nxt = mode;
        if (ev_up)        dir_nxt = AUTO_UP;
        else if (ev_down) dir_nxt = AUTO_DOWN;
    end

    // Stage p4: arbitration and registered step outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            mode        <= MANUAL;
            presc       <= '0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
        end else begin
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            if (ev_blank || (ev_up && ev_down)) begin
                step_up_q   <= 1'b1;
                step_down_q <= 1'b1;
                mode        <= MANUAL;
                presc       <= '0;
            end else if (ev_auto) begin
                mode  <= (mode == MANUAL) ? AUTO_UP : MANUAL;
                presc <= '0;
            end else if (mode == MANUAL) begin
                if (ev_up) begin
                    step_up_q <= 1'b1;
                    presc     <= '0;
                end else if (ev_down) begin
                    step_down_q <= 1'b1;
                    presc       <= '0;
                end else if (tick) begin
                    step_up_q   <= deb_p2[0];
                    step_down_q <= deb_p2[1];
                    presc       <= '0;
                end else begin
                    presc <= count_en ? presc + CNT_ONE : '0;
                end
            end else begin
                mode <= dir_nxt;
                if (tick) begin
                    step_up_q   <= (dir_nxt == AUTO_UP);
                    step_down_q <= (dir_nxt == AUTO_DOWN);
                    presc       <= '0;
                end else begin
                    presc <= presc + CNT_ONE;
                end
            end
        end
    end

    assign bus.step_up   = step_up_q;
    assign bus.step_down = step_down_q;
    assign bus.mode      = mode;

endmodule

// File: tb/tb_seq_step_controller.sv
// Directed bench for seq_step_controller with DEB_CYCLES=4, TICK_DIV=8.
// Outputs are observed as {step_up, step_down, mode} 1 ns after each rising edge.
module tb_seq_step_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    seq_step_controller_if bus ();

    seq_step_controller #(
        .DEB_CYCLES(16'd4),
        .TICK_DIV  (32'd8),
        .CNT_W     (32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic edge1();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] obs();
        return {bus.step_up, bus.step_down, bus.mode};
    endfunction

    task automatic test_reset();
        logic [3:0] o;
        reset         = 1'b1;
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_auto  = 1'b0;
        bus.btn_blank = 1'b0;
        repeat (3) edge1();
        o = obs();
        total++;
        if (o !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0000", o);
        end
        total++;
        if (dut.deb_p2 !== 4'b0000) begin
            bad++;
            $display("FAIL reset_debounce: got %b want 0000", dut.deb_p2);
        end
        reset = 1'b0;
        edge1();
        o = obs();
        total++;
        if (o !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release: got %b want 0000", o);
        end
    endtask

    task automatic test_manual_up();
        logic [3:0] o, exp;
        bus.btn_up = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            edge1();
            o   = obs();
            exp = (e == 7) ? 4'b1000 : 4'b0000;
            total++;
            if (o !== exp) begin
                bad++;
                $display("FAIL manual_up edge %0d: got %b want %b", e, o, exp);
            end
            if (e == 7) bus.btn_up = 1'b0;
        end
    endtask

    task automatic test_glitch();
        logic [3:0] o;
        bus.btn_down = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            edge1();
            o = obs();
            total++;
            if (o !== 4'b0000) begin
                bad++;
                $display("FAIL glitch edge %0d: got %b want 0000", e, o);
            end
            if (e == 3) bus.btn_down = 1'b0;
        end
        total++;
        if (dut.deb_p2[1] !== 1'b0) begin
            bad++;
            $display("FAIL glitch_level: got %b want 0", dut.deb_p2[1]);
        end
    endtask

    task automatic test_auto();
        logic [3:0] o, exp;
        logic [1:0] m;
        bus.btn_auto = 1'b1;
        for (int e = 1; e <= 58; e++) begin
            edge1();
            o = obs();
            m = (e < 7) ? 2'b00 : (e < 39) ? 2'b01 : 2'b10;
            if (e == 15 || e == 23 || e == 31)      exp = {2'b10, m};
            else if (e == 39 || e == 47 || e == 55) exp = {2'b01, m};
            else                                    exp = {2'b00, m};
            total++;
            if (o !== exp) begin
                bad++;
                $display("FAIL auto edge %0d: got %b want %b", e, o, exp);
            end
            if (e == 10) bus.btn_auto = 1'b0;
            if (e == 32) bus.btn_down = 1'b1;
            if (e == 42) bus.btn_down = 1'b0;
        end
    endtask

    task automatic test_blank();
        logic [3:0] o, exp;
        bus.btn_blank = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            edge1();
            o = obs();
            if (e == 5)      exp = 4'b0110;
            else if (e == 7) exp = 4'b1100;
            else if (e < 7)  exp = 4'b0010;
            else             exp = 4'b0000;
            total++;
            if (o !== exp) begin
                bad++;
                $display("FAIL blank edge %0d: got %b want %b", e, o, exp);
            end
            if (e == 10) bus.btn_blank = 1'b0;
        end
    endtask

    task automatic test_both_and_reset();
        logic [3:0] o, exp;
        bus.btn_up   = 1'b1;
        bus.btn_down = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            edge1();
            o   = obs();
            exp = (e == 7) ? 4'b1100 : 4'b0000;
            total++;
            if (o !== exp) begin
                bad++;
                $display("FAIL both edge %0d: got %b want %b", e, o, exp);
            end
            if (e == 8) begin
                bus.btn_up   = 1'b0;
                bus.btn_down = 1'b0;
            end
        end
        bus.btn_up = 1'b1;
        for (int e = 1; e <= 28; e++) begin
            edge1();
            o   = obs();
            exp = (e == 15) ? 4'b1000 : 4'b0000;
            total++;
            if (o !== exp) begin
                bad++;
                $display("FAIL reset_abort edge %0d: got %b want %b", e, o, exp);
            end
            if (e == 6)  reset = 1'b1;
            if (e == 8)  reset = 1'b0;
            if (e == 15) bus.btn_up = 1'b0;
        end
    endtask

    task automatic test_repeat();
        logic [3:0] o, exp;
        bus.btn_up = 1'b1;
        for (int e = 1; e <= 45; e++) begin
            edge1();
            o = obs();
`ifdef AUTOREPEAT_EN
            exp = (e == 7 || e == 15 || e == 23 || e == 31) ? 4'b1000 : 4'b0000;
`else
            exp = (e == 7) ? 4'b1000 : 4'b0000;
`endif
            total++;
            if (o !== exp) begin
                bad++;
                $display("FAIL repeat edge %0d: got %b want %b", e, o, exp);
            end
            if (e == 31) bus.btn_up = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_manual_up();
        test_glitch();
        test_auto();
        test_blank();
        test_both_and_reset();
        test_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
